// File: rtl/cpu_run_ctrl.sv
// CPU run controller: start/step edge detection, INIT flush pulse, RUN, HALT drain, DONE.
// Optional single-step support is compiled in with `define RUN_CTRL_STEP_EN.
module cpu_run_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic        step,
  input  logic        halt_ins,
  output logic        cpu_run,
  output logic        pc_init,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] cyc_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    INIT  = 3'b001,
    RUN   = 3'b010,
    DRAIN = 3'b011,
    STEP  = 3'b100,
    DONE  = 3'b101
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [15:0] cyc_q, cyc_d;
  logic        start_q, step_q;
  logic        start_e, step_e;
  logic        run_dec;

  // Edge registers reset high so an input held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      cyc_q   <= '0;
      start_q <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      start_q <= start;
      step_q  <= step;
    end
  end

  assign start_e = start & ~start_q;

`ifdef RUN_CTRL_STEP_EN
  assign step_e  = step & ~step_q;
  assign run_dec = (state_q == RUN) || (state_q == DRAIN) || (state_q == STEP);
`else
  logic unused_step_q;
  assign unused_step_q = step_q;
  assign step_e  = 1'b0;
  assign run_dec = (state_q == RUN) || (state_q == DRAIN);
`endif

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cyc_d   = cyc_q;
    if (enable && run_dec && (cyc_q != '1)) begin
      cyc_d = cyc_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (enable && start_e) begin
          state_d = INIT;
        end else if (enable && step_e) begin
          state_d = STEP;
        end
      end
      INIT: begin
        if (enable) begin
          cyc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (enable && halt_ins) begin
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (enable) begin
          if (drain_q == '0) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end
`ifdef RUN_CTRL_STEP_EN
      STEP: begin
        if (enable) begin
          if (halt_ins) begin
            drain_d = DRAIN_LOAD;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      DONE: begin
        if (enable && start_e) begin
          state_d = INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_run = enable & run_dec;
  assign pc_init = enable & (state_q == INIT);
  assign busy    = (state_q == INIT) | run_dec;
  assign halted  = (state_q == DONE);
  assign state   = state_q;
  assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes model expectations, a monitor compares each cycle.
module tb_cpu_run_ctrl;
  localparam int unsigned D = 3;

`ifdef RUN_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        halt_ins = 1'b0;
  logic        cpu_run, pc_init, busy, halted;
  logic [2:0]  state;
  logic [15:0] cyc_cnt;

  cpu_run_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .step(step),
    .halt_ins(halt_ins), .cpu_run(cpu_run), .pc_init(pc_init), .busy(busy),
    .halted(halted), .state(state), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          phase;
    logic        run;
    logic        pinit;
    logic        bsy;
    logic        hlt;
    logic [2:0]  st;
    logic [15:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int phase = 0;

  // Reference model: named run modes, a count of drain cycles still owed, and a run-cycle tally.
  string m_mode = "IDLE";
  int    m_drain_left = 0;
  int    m_cyc = 0;
  bit    m_prev_start = 1'b1;
  bit    m_prev_step = 1'b1;

  function automatic logic [2:0] code_of(input string m);
    if (m == "INIT")  return 3'd1;
    if (m == "RUN")   return 3'd2;
    if (m == "DRAIN") return 3'd3;
    if (m == "STEP")  return 3'd4;
    if (m == "DONE")  return 3'd5;
    return 3'd0;
  endfunction

  function automatic bit running(input string m);
    return (m == "RUN") || (m == "DRAIN") || (m == "STEP");
  endfunction

  task automatic model_reset();
    m_mode = "IDLE";
    m_drain_left = 0;
    m_cyc = 0;
    m_prev_start = 1'b1;
    m_prev_step = 1'b1;
  endtask

  task automatic model_advance(input bit en, input bit s, input bit st, input bit h);
    bit s_edge, st_edge;
    s_edge = s && !m_prev_start;
    st_edge = st && !m_prev_step && STEP_EN;
    m_prev_start = s;
    m_prev_step = st;
    if (!en) return;
    if (running(m_mode) && m_cyc < 65535) m_cyc = m_cyc + 1;
    if (m_mode == "IDLE") begin
      if (s_edge) m_mode = "INIT";
      else if (st_edge) m_mode = "STEP";
    end else if (m_mode == "INIT") begin
      m_cyc = 0;
      m_mode = "RUN";
    end else if (m_mode == "RUN" || m_mode == "STEP") begin
      if (h) begin
        m_drain_left = D;
        m_mode = "DRAIN";
      end else if (m_mode == "STEP") begin
        m_mode = "IDLE";
      end
    end else if (m_mode == "DRAIN") begin
      m_drain_left = m_drain_left - 1;
      if (m_drain_left == 0) m_mode = "DONE";
    end else if (m_mode == "DONE") begin
      if (s_edge) m_mode = "INIT";
    end
  endtask

  task automatic tick(input bit r, input bit en, input bit s, input bit st, input bit h);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; enable = en; start = s; step = st; halt_ins = h;
    e.phase = phase;
    if (r) begin
      e.run = 1'b0; e.pinit = 1'b0; e.bsy = 1'b0; e.hlt = 1'b0; e.st = 3'd0; e.cyc = 16'd0;
    end else begin
      e.run   = en && running(m_mode);
      e.pinit = en && (m_mode == "INIT");
      e.bsy   = running(m_mode) || (m_mode == "INIT");
      e.hlt   = (m_mode == "DONE");
      e.st    = code_of(m_mode);
      e.cyc   = 16'(m_cyc);
    end
    exp_q.push_back(e);
    if (r) model_reset();
    else model_advance(en, s, st, h);
  endtask

  // Monitor: every falling edge the DUT presents one cycle of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compared++;
        if ({cpu_run, pc_init, busy, halted, state, cyc_cnt} !==
            {e.run, e.pinit, e.bsy, e.hlt, e.st, e.cyc}) begin
          mismatched++;
          $display("FAIL phase%0d t=%0t: got run=%b pc_init=%b busy=%b halted=%b state=%0d cyc=%0d, want run=%b pc_init=%b busy=%b halted=%b state=%0d cyc=%0d",
                   e.phase, $time, cpu_run, pc_init, busy, halted, state, cyc_cnt,
                   e.run, e.pinit, e.bsy, e.hlt, e.st, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset with start held high; no run may follow until start falls and rises again.
    phase = 0;
    repeat (3) tick(1, 1, 1, 0, 0);
    repeat (4) tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, 0);

    // Start, INIT pulse, 10 RUN cycles; a start edge mid-run is ignored.
    phase = 1;
    tick(0, 1, 1, 0, 0);
    repeat (6) tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    repeat (4) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    repeat (5) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, 0);
    tick(0, 1, 0, 0, 0);

    // From DONE: 20 RUN cycles, HALT, drain of D cycles, DONE with cyc_cnt 24.
    phase = 2;
    tick(0, 1, 1, 0, 0);
    repeat (21) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    repeat (6) tick(0, 1, 0, 0, 0);

    // Freeze for 5 cycles mid-RUN with a start pulse inside; resume without INIT.
    phase = 3;
    tick(0, 1, 1, 0, 0);
    repeat (6) tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0, 0);
    repeat (5) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    repeat (6) tick(0, 1, 0, 0, 0);

    // From IDLE: three step pulses, then start and step rising together.
    phase = 4;
    repeat (2) tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 1, 0);
      repeat (2) tick(0, 1, 0, 0, 0);
    end
    tick(0, 1, 1, 1, 0);
    repeat (4) tick(0, 1, 0, 0, 0);

    // Reset during DRAIN with start held high across the reset.
    phase = 5;
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 1, 0, 0);
    repeat (2) tick(1, 1, 1, 0, 0);
    repeat (3) tick(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    repeat (4) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    repeat (5) tick(0, 1, 0, 0, 0);

    // Random traffic.
    phase = 6;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0);
    end

    // Long run past the counter limit: cyc_cnt must hold at FFFF.
    phase = 7;
    repeat (2) tick(1, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    repeat (65542) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    repeat (5) tick(0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_queue: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: pipeline cycles kept running after HALT is decoded; legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  global run permission; 0 freezes the controller.
REQ-005 start  in  1  level input; rising edge requests a full run from PC 0.
REQ-006 step  in  1  level input; rising edge requests one pipeline advance.
REQ-007 halt_ins  in  1  high while the ID stage holds a HALT instruction.
REQ-008 cpu_run  out  1  pipeline advance enable.
REQ-009 pc_init  out  1  one-cycle pulse: PC := 0 and pipeline registers flushed.
REQ-010 busy  out  1  high in INIT, RUN, DRAIN and STEP.
REQ-011 halted  out  1  high in DONE.
REQ-012 state  out  3  current state encoding.
REQ-013 cyc_cnt  out  16  cycles with cpu_run=1 since the last INIT.

Function
REQ-014 States, with encodings: IDLE=000, INIT=001, RUN=010, DRAIN=011, STEP=100, DONE=101; other codes go to IDLE on the next edge.
REQ-015 Edge detect: start_q/step_q register the inputs every cycle regardless of enable; start_e = start & ~start_q, and step_e is formed the same way.
REQ-016 IDLE: if enable and start_e, go to INIT; otherwise, if enable and step_e, go to STEP; start wins when both occur.
REQ-017 INIT: pc_init=1, cpu_run=0, cyc_cnt cleared to 0, then go to RUN; pc_init lasts exactly one cycle.
REQ-018 Start latency: a start edge sampled at edge n gives pc_init high in cycle n+1 and cpu_run high from cycle n+2.
REQ-019 RUN: cpu_run=1; on halt_ins=1, load drain_cnt := DRAIN_CYCLES-1 and go to DRAIN; start_e and step_e are ignored.
REQ-020 DRAIN: cpu_run=1; halt_ins is ignored; when drain_cnt=0, go to DONE, otherwise decrement drain_cnt.
REQ-021 DRAIN length: cpu_run stays high for exactly DRAIN_CYCLES cycles in DRAIN.
REQ-022 STEP: cpu_run=1 for exactly one cycle; then go to DRAIN if halt_ins=1 (drain_cnt loaded as in RUN), otherwise to IDLE.
REQ-023 DONE: cpu_run=0 and halted=1; start_e with enable goes to INIT; step_e is ignored.
REQ-024 cyc_cnt increments in every cycle where cpu_run=1 and saturates at 16'hFFFF (no wrap).
REQ-025 Freeze: enable=0 in any state forces cpu_run=0 and pc_init=0, and holds state, drain_cnt and cyc_cnt.
REQ-026 Edges arriving while enable=0 are discarded, not queued.
REQ-027 Outputs are decoded from registered state only, with no input-to-output combinational path, except for the enable gating of cpu_run and pc_init.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, cpu_run=0, pc_init=0, busy=0, halted=0, cyc_cnt=0, drain_cnt=0, start_q=1, step_q=1.
REQ-029 start_q and step_q reset to 1 so that an input held high through reset does not produce an edge.
REQ-030 Reset mid-run (any state) aborts immediately; the first post-reset run requires a fresh start edge.

Configuration
REQ-031 Macro RUN_CTRL_STEP_EN: when defined, the step input and STEP state are implemented as specified above.
REQ-032 When RUN_CTRL_STEP_EN is undefined, step is ignored, STEP is never entered, and code 100 is treated as illegal (goes to IDLE).

Verification
REQ-033 Reset release, enable=1, start pulse at edge 0, halt_ins never set -> pc_init high in cycle 1 only; cpu_run=1 from cycle 2; cyc_cnt=10 after 10 RUN cycles; state=010.
REQ-034 Run with halt_ins pulsed after 20 RUN cycles, DRAIN_CYCLES=3 -> exactly 3 DRAIN cycles with cpu_run=1, then state=101, halted=1, cpu_run=0, cyc_cnt=24.
REQ-035 enable=0 for 5 cycles mid-RUN, with a start pulse during the freeze -> cpu_run=0, cyc_cnt and state held; RUN resumes without a new INIT.
REQ-036 From IDLE, with RUN_CTRL_STEP_EN defined, 3 step pulses -> 3 single-cycle cpu_run pulses and cyc_cnt=3; start and step rising together -> INIT.
REQ-037 rst asserted in DRAIN -> all outputs 0 and state=000 within the same cycle; start held high across reset -> no run until start falls and rises again.
REQ-038 cyc_cnt preloaded near the limit (long run of 65540 cycles) -> cyc_cnt holds at FFFF.
